ysyx_22050612_exu_mdu: RTL

Iterative multiply/divide execute unit for the RV64M (or RV32M) extension. It sits beside the single-cycle integer EXU. The EXU routes M-extension ops here through a valid/ready handshake and stalls until the result returns with its destination tag. The block is parametrised in operand width and tag width, supports word (`*W`) variants, and handles divide-by-zero, overflow, back-pressure and flush.

---
 rtl/ysyx_22050612_pkg.sv | 49 ++++
 rtl/ysyx_22050612_mdu_step.sv | 30 +++
 rtl/ysyx_22050612_exu_mdu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050612_pkg.sv
// Shared constants and helpers for the ysyx_22050612 execute units.
// Holds the M-extension funct3 codes, MDU FSM encoding and the op decode used at accept.
package ysyx_22050612_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  typedef struct packed {
    logic is_div;  // DIV/DIVU/REM/REMU
    logic is_rem;  // REM/REMU
    logic high;    // MULH/MULHSU/MULHU
    logic s1;      // src1 interpreted as signed
    logic s2;      // src2 interpreted as signed
  } mdu_dec_t;

  // Quotient returned on divide-by-zero: the low w bits set.
  function automatic logic [63:0] mdu_all_ones(input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

  // MUL is treated as unsigned: the low half of the product does not depend on signedness.
  function automatic mdu_dec_t mdu_decode(input logic [2:0] op);
    mdu_dec_t d;
    d.is_div = op[2];
    d.is_rem = op[2] & op[1];
    d.high   = ~op[2] & (op != MDU_MUL);
    d.s1     = (op == MDU_MULH) | (op == MDU_MULHSU) | (op == MDU_DIV) | (op == MDU_REM);
    d.s2     = (op == MDU_MULH) | (op == MDU_DIV) | (op == MDU_REM);
    return d;
  endfunction

endpackage

// File: rtl/ysyx_22050612_mdu_step.sv
// One combinational MDU iteration on the 2*XLEN working register.
// Multiply: conditional add of opnd into the high half, then shift right. Divide: restoring shift-subtract.
module ysyx_22050612_mdu_step #(
  parameter int XLEN = 64
) (
  input  logic                div_mode,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     opnd,
  output logic [2*XLEN-1:0]   acc_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] part;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // Partial remainder shifted left with the next dividend bit; XLEN+1 bits so the compare never wraps.
    part = acc[2*XLEN-1:XLEN-1];
    diff = part - {1'b0, opnd};
    if (!div_mode) begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ysyx_22050612_exu_mdu.sv
// Iterative RV64M/RV32M multiply/divide unit: N+1 edges from accept to result (N = XLEN or 32), 1 for special divides.
// Result is held in DONE until out_ready; a new op is accepted only from IDLE, flush kills everything.
module ysyx_22050612_exu_mdu
  import ysyx_22050612_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] N_FULL = CW'(XLEN);
  localparam logic [CW-1:0] N_WORD = CW'(32);

  mdu_state_t        state;
  mdu_dec_t          dec;
  mdu_dec_t          r_dec;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   opnd;
  logic              r_word;
  logic              r_sp;
  logic              neg_q;
  logic              neg_r;

  logic              word_eff;
  logic              neg1;
  logic              neg2;
  logic              div0;
  logic              ovf;
  logic [XLEN-1:0]   v1;
  logic [XLEN-1:0]   v2;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic [XLEN-1:0]   min_neg;
  logic [XLEN-1:0]   sp_res;
  logic [63:0]       ones64;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   val;
  logic [XLEN-1:0]   fix_res;

  assign ones64   = mdu_all_ones(XLEN);
  assign in_ready = (state == MDU_IDLE) & ~flush & rst_n;

  // Accept-side decode: operand extension, magnitudes and special-case detection.
  always_comb begin
    dec      = mdu_decode(in_op);
    word_eff = (XLEN == 64) && in_word && !dec.high;
    if (word_eff) begin
      v1      = dec.s1 ? XLEN'($signed(in_src1[31:0])) : XLEN'(in_src1[31:0]);
      v2      = dec.s2 ? XLEN'($signed(in_src2[31:0])) : XLEN'(in_src2[31:0]);
      min_neg = XLEN'($signed(32'h8000_0000));
    end else begin
      v1      = in_src1;
      v2      = in_src2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    neg1 = dec.s1 & v1[XLEN-1];
    neg2 = dec.s2 & v2[XLEN-1];
    mag1 = neg1 ? -v1 : v1;
    mag2 = neg2 ? -v2 : v2;
    div0 = dec.is_div && (v2 == '0);
    ovf  = dec.is_div && dec.s1 && (v1 == min_neg) && (v2 == '1);
    sp_res = ones64[XLEN-1:0];
    if (dec.is_rem) begin
      sp_res = div0 ? (word_eff ? XLEN'($signed(in_src1[31:0])) : in_src1) : '0;
    end else if (!div0) begin
      sp_res = v1;
    end
  end

  ysyx_22050612_mdu_step #(.XLEN(XLEN)) u_step (
    .div_mode (r_dec.is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_nxt  (acc_nxt)
  );

  // Sign fixup; a word multiply ran only 32 steps, so its product sits XLEN-32 bits up.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (r_dec.is_div) begin
      val = r_dec.is_rem ? rem : quo;
    end else if (r_dec.high) begin
      val = prod[2*XLEN-1:XLEN];
    end else begin
      val = r_word ? (prod[XLEN-1:0] >> (XLEN - 32)) : prod[XLEN-1:0];
    end
    fix_res = r_word ? XLEN'($signed(val[31:0])) : val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= MDU_IDLE;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      r_dec      <= '0;
      r_word     <= 1'b0;
      r_sp       <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= MDU_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (in_valid) begin
            r_dec   <= dec;
            r_word  <= word_eff;
            neg_q   <= neg1 ^ neg2;
            neg_r   <= neg1;
            out_tag <= in_tag;
            state   <= MDU_BUSY;
            if (dec.is_div) begin
              opnd <= mag2;
              acc  <= {{XLEN{1'b0}}, word_eff ? (mag1 << (XLEN - 32)) : mag1};
            end else begin
              opnd <= mag1;
              acc  <= {{XLEN{1'b0}}, mag2};
            end
            // Special divides spend one zero-iteration BUSY cycle so the result lands after the next edge.
            if (div0 | ovf) begin
              r_sp       <= 1'b1;
              cnt        <= '0;
              out_result <= sp_res;
            end else begin
              r_sp <= 1'b0;
              cnt  <= word_eff ? N_WORD : N_FULL;
            end
          end
        end
        MDU_BUSY: begin
          if (cnt != '0) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
          end else begin
            if (!r_sp) out_result <= fix_res;
            out_valid <= 1'b1;
            state     <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= MDU_IDLE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule
